external_bus_responder: RTL and testbench

Memory-side responder for the 8-bit core's external bus: it serves the accesses that the datapath initiates on ABH/ABL, the data-output bus and the write strobe. It decodes a 16-bit address into four regions: a small RAM, one memory-mapped output port, a fixed vector table, and unmapped space. It inserts a programmable number of wait states and stalls the core through a RDY-style `ready` output. It is the bench and FPGA stand-in for real memory behind the CPU.

---
 rtl/external_bus_responder.sv | 130 +++++++++++++
 tb/tb_external_bus_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/external_bus_responder.sv
// rtl/external_bus_responder.sv - external bus responder: RAM, output port, vector table, wait states
module external_bus_responder #(
   parameter int          MEM_DEPTH    = 256,
   parameter int          WAIT_STATES  = 1,
   parameter logic [15:0] PORT_ADDR    = 16'h4000,
   parameter logic [15:0] NMI_VECTOR   = 16'hFFF0,
   parameter logic [15:0] RESET_VECTOR = 16'h8000,
   parameter logic [15:0] IRQ_VECTOR   = 16'hFFF8
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] addressLow,
   input  logic [7:0] addressHigh,
   input  logic [7:0] dataFromCPU,
   input  logic       writeEnable,
   input  logic       accessValid,
   output logic [7:0] dataToCPU,
   output logic       ready,
   output logic [7:0] portOut,
   output logic       busError
);
   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_count;
   logic [3:0]  w_next_count;
   logic [15:0] r_addr;
   logic [7:0]  r_wdata;
   logic        r_we;
   logic [7:0]  r_mem [MEM_DEPTH];
   logic [7:0]  r_rdata;
   logic [7:0]  r_port;
   logic        r_err;
   logic        w_accept;
   logic        w_commit;
   logic        w_is_vec;
   logic        w_is_port;
   logic        w_is_ram;
   logic [15:0] w_vec;
   logic [7:0]  w_vec_byte;

   assign w_accept = (r_state == S_IDLE) && accessValid;
   assign w_commit = (r_state == S_ACCESS);

   always_comb begin
      w_next_state = r_state;
      w_next_count = r_count;
      case (r_state)
         S_IDLE: begin
            if (accessValid) begin
               if (WAIT_STATES == 0) begin
                  w_next_state = S_ACCESS;
               end else begin
                  w_next_state = S_WAIT;
                  w_next_count = 4'(WAIT_STATES);
               end
            end
         end
         S_WAIT: begin
            w_next_count = r_count - 4'd1;
            if (r_count == 4'd1) w_next_state = S_ACCESS;
         end
         S_ACCESS: w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         r_state <= S_IDLE;
         r_count <= 4'd0;
      end else begin
         r_state <= w_next_state;
         r_count <= w_next_count;
      end
   end

   // Request is captured once at acceptance; the core may change the bus afterwards.
   always_ff @(posedge clk) begin
      if (nrst) begin
         r_addr  <= 16'h0000;
         r_wdata <= 8'h00;
         r_we    <= 1'b0;
      end else if (w_accept) begin
         r_addr  <= {addressHigh, addressLow};
         r_wdata <= dataFromCPU;
         r_we    <= writeEnable;
      end
   end

   // Vector table and port win over RAM when ranges overlap.
   assign w_is_vec   = (r_addr >= 16'hFFFA);
   assign w_is_port  = !w_is_vec && (r_addr == PORT_ADDR);
   assign w_is_ram   = !w_is_vec && !w_is_port && (r_addr < 16'(MEM_DEPTH));
   assign w_vec      = (r_addr[2:1] == 2'b01) ? NMI_VECTOR :
                       (r_addr[2:1] == 2'b10) ? RESET_VECTOR : IRQ_VECTOR;
   assign w_vec_byte = r_addr[0] ? w_vec[15:8] : w_vec[7:0];

   always_ff @(posedge clk) begin
      if (nrst) begin
         r_rdata <= 8'h00;
         r_port  <= 8'h00;
         r_err   <= 1'b0;
      end else if (w_commit) begin
         if (w_is_vec) begin
            if (!r_we) r_rdata <= w_vec_byte;
         end else if (w_is_port) begin
            if (r_we) r_port <= r_wdata;
            else      r_rdata <= r_port;
         end else if (w_is_ram) begin
            if (!r_we) r_rdata <= r_mem[r_addr[AW-1:0]];
         end else begin
            r_err <= 1'b1;
            if (!r_we) r_rdata <= 8'hFF;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst && w_commit && w_is_ram && r_we) r_mem[r_addr[AW-1:0]] <= r_wdata;
   end

   assign ready     = (r_state == S_IDLE);
   assign dataToCPU = r_rdata;
   assign portOut   = r_port;
   assign busError  = r_err;
endmodule

// File: tb/tb_external_bus_responder.sv
// tb/tb_external_bus_responder.sv - directed table, reset sequences and random model check
module tb_external_bus_responder;
   localparam int          WS    = 2;
   localparam int          DEPTH = 256;
   localparam logic [15:0] NMI_V = 16'hFFF0;
   localparam logic [15:0] RST_V = 16'h8000;
   localparam logic [15:0] IRQ_V = 16'hFFF8;

   logic       clk = 1'b0;
   logic       nrst = 1'b1;
   logic [7:0] addressLow = 8'h00;
   logic [7:0] addressHigh = 8'h00;
   logic [7:0] dataFromCPU = 8'h00;
   logic       writeEnable = 1'b0;
   logic       accessValid = 1'b0;
   logic [7:0] dataToCPU;
   logic       ready;
   logic [7:0] portOut;
   logic       busError;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp_data;
      logic [7:0]  exp_port;
      logic        exp_err;
   } vec_t;

   vec_t tbl [16];

   logic [7:0] mem_m [DEPTH];
   bit         valid_m [DEPTH];
   logic [7:0] data_m;
   logic [7:0] port_m;
   logic       err_m;

   external_bus_responder #(
      .MEM_DEPTH(DEPTH), .WAIT_STATES(WS), .PORT_ADDR(16'h4000),
      .NMI_VECTOR(NMI_V), .RESET_VECTOR(RST_V), .IRQ_VECTOR(IRQ_V)
   ) dut (
      .clk(clk), .nrst(nrst), .addressLow(addressLow), .addressHigh(addressHigh),
      .dataFromCPU(dataFromCPU), .writeEnable(writeEnable), .accessValid(accessValid),
      .dataToCPU(dataToCPU), .ready(ready), .portOut(portOut), .busError(busError)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Presents one access on the first cycle ready is seen high, then scrambles the bus.
   task automatic access(input logic we, input logic [15:0] a, input logic [7:0] d, input int idle);
      int guard;
      int cnt;
      repeat (idle) @(negedge clk);
      guard = 0;
      while (!ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("ready_before_access", 32'(ready), 32'd1);
      writeEnable = we;
      {addressHigh, addressLow} = a;
      dataFromCPU = d;
      accessValid = 1'b1;
      @(negedge clk);
      accessValid = 1'b0;
      writeEnable = 1'($urandom);
      addressLow  = 8'($urandom);
      addressHigh = 8'($urandom);
      dataFromCPU = 8'($urandom);
      cnt = 0;
      while (!ready && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("stall_cycles", 32'(cnt), 32'(WS + 1));
   endtask

   function automatic logic [7:0] vec_byte(input logic [15:0] a);
      logic [15:0] v;
      if (a < 16'hFFFC)      v = NMI_V;
      else if (a < 16'hFFFE) v = RST_V;
      else                   v = IRQ_V;
      return a[0] ? v[15:8] : v[7:0];
   endfunction

   initial begin
      tbl[0]  = '{1'b1, 16'h0010, 8'h5A, 8'h00, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 16'h0010, 8'h00, 8'h5A, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 16'hFFFC, 8'h00, 8'h00, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 16'hFFFD, 8'h00, 8'h80, 8'h00, 1'b0};
      tbl[4]  = '{1'b1, 16'hFFFC, 8'h12, 8'h80, 8'h00, 1'b0};
      tbl[5]  = '{1'b0, 16'hFFFC, 8'h00, 8'h00, 8'h00, 1'b0};
      tbl[6]  = '{1'b1, 16'h0000, 8'h11, 8'h00, 8'h00, 1'b0};
      tbl[7]  = '{1'b1, 16'h4000, 8'hA5, 8'h00, 8'hA5, 1'b0};
      tbl[8]  = '{1'b0, 16'h4000, 8'h00, 8'hA5, 8'hA5, 1'b0};
      tbl[9]  = '{1'b0, 16'h0000, 8'h00, 8'h11, 8'hA5, 1'b0};
      tbl[10] = '{1'b0, 16'hFFFA, 8'h00, 8'hF0, 8'hA5, 1'b0};
      tbl[11] = '{1'b0, 16'hFFFB, 8'h00, 8'hFF, 8'hA5, 1'b0};
      tbl[12] = '{1'b0, 16'hFFFF, 8'h00, 8'hFF, 8'hA5, 1'b0};
      tbl[13] = '{1'b0, 16'hFFFE, 8'h00, 8'hF8, 8'hA5, 1'b0};
      tbl[14] = '{1'b0, 16'h2000, 8'h00, 8'hFF, 8'hA5, 1'b1};
      tbl[15] = '{1'b0, 16'h0010, 8'h00, 8'h5A, 8'hA5, 1'b1};

      repeat (3) @(negedge clk);
      check("reset_ready", 32'(ready), 32'd1);
      check("reset_data", 32'(dataToCPU), 32'h00);
      check("reset_port", 32'(portOut), 32'h00);
      check("reset_err", 32'(busError), 32'd0);
      nrst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         access(tbl[i].we, tbl[i].addr, tbl[i].wdata, int'($urandom_range(0, 2)));
         check($sformatf("tbl%0d_data", i), 32'(dataToCPU), 32'(tbl[i].exp_data));
         check($sformatf("tbl%0d_port", i), 32'(portOut), 32'(tbl[i].exp_port));
         check($sformatf("tbl%0d_err", i), 32'(busError), 32'(tbl[i].exp_err));
      end

      // Reset during WAIT drops the pending write and clears all visible state.
      access(1'b1, 16'h0020, 8'h77, 0);
      writeEnable = 1'b1;
      {addressHigh, addressLow} = 16'h0020;
      dataFromCPU = 8'h33;
      accessValid = 1'b1;
      @(negedge clk);
      accessValid = 1'b0;
      check("abort_in_wait", 32'(ready), 32'd0);
      nrst = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset_ready", 32'(ready), 32'd1);
      check("midreset_data", 32'(dataToCPU), 32'h00);
      check("midreset_port", 32'(portOut), 32'h00);
      check("midreset_err", 32'(busError), 32'd0);
      nrst = 1'b0;
      access(1'b0, 16'h0020, 8'h00, 1);
      check("dropped_write", 32'(dataToCPU), 32'h77);

      data_m = 8'h77;
      port_m = 8'h00;
      err_m  = 1'b0;
      for (int i = 0; i < DEPTH; i++) valid_m[i] = 1'b0;

      for (int n = 0; n < 300; n++) begin
         logic [15:0] a;
         logic [7:0]  d;
         logic        we;
         int          sel;
         sel = int'($urandom_range(0, 19));
         we  = 1'($urandom);
         d   = 8'($urandom);
         if (sel < 13)      a = 16'($urandom_range(0, DEPTH - 1));
         else if (sel < 16) a = 16'h4000;
         else if (sel < 19) a = 16'($urandom_range(16'hFFFA, 16'hFFFF));
         else begin
            do a = 16'($urandom_range(DEPTH, 16'hFFF9)); while (a == 16'h4000);
         end
         if (a < DEPTH && !we && !valid_m[a]) we = 1'b1;

         if (a >= 16'hFFFA) begin
            if (!we) data_m = vec_byte(a);
         end else if (a == 16'h4000) begin
            if (we) port_m = d;
            else    data_m = port_m;
         end else if (a < DEPTH) begin
            if (we) begin
               mem_m[a]   = d;
               valid_m[a] = 1'b1;
            end else begin
               data_m = mem_m[a];
            end
         end else begin
            err_m = 1'b1;
            if (!we) data_m = 8'hFF;
         end

         access(we, a, d, int'($urandom_range(0, 2)));
         check($sformatf("rnd%0d_data a=%h we=%0d", n, a, we), 32'(dataToCPU), 32'(data_m));
         check($sformatf("rnd%0d_port", n), 32'(portOut), 32'(port_m));
         check($sformatf("rnd%0d_err", n), 32'(busError), 32'(err_m));
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
